alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue stage: the operand/opcode producer for the pipeline ALU. Decodes a MIPS instruction word.
//  Reads the register file, resolves hazards and registers {op, A, B, dst} into the ID/EX register.
//  The ALU samples these outputs combinationally in EX. Sits between IF/ID and the ALU.
// PARAMETERS
//  XLEN      32  datapath width
//  RADDR_W   5   register index width
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-high reset
//  in_valid    in   1     IF/ID holds a valid instruction
//  in_ready    out  1     instruction accepted this edge (0 = stall, IF/ID must hold)
//  in_instr    in   32    instruction word
//  in_pc       in   32    PC of in_instr
//  flush       in   1     squash the instruction in ID (taken branch/jump)
//  rf_raddr1   out  5     regfile read index = instr[25:21] (rs)
//  rf_raddr2   out  5     regfile read index = instr[20:16] (rt)
//  rf_rdata1   in   32    regfile data, combinational, write-first
//  rf_rdata2   in   32    regfile data, combinational, write-first
//  mem_valid   in   1     EX/MEM holds a writing instruction
//  mem_dst     in   5     EX/MEM destination register
//  mem_result  in   32    EX/MEM ALU result
//  wb_valid    in   1     MEM/WB holds a writing instruction
//  wb_dst      in   5     MEM/WB destination register
//  wb_result   in   32    MEM/WB write-back value
//  out_valid   out  1     ID/EX holds a real instruction
//  out_op      out  4     ALU op code
//  out_a       out  32    ALU operand A
//  out_b       out  32    ALU operand B
//  out_dst     out  5     destination register (0 = none)
//  out_is_load out  1     lw in EX
//  out_is_store out 1     sw in EX; store data in out_sdata
//  out_sdata   out  32    rt value for sw
//  out_jr      out  1     jr in EX
//  out_branch  out  1     beq in EX (EX checks ALU zero)
//  illegal     out  1     one-cycle pulse: unsupported instruction dropped
// BEHAVIOUR
//  - Reset: all out_* = 0; out_op = 4'b0000 (ALU no-op); illegal = 0. Latency 1: accepted at edge N -> out_* valid after edge N.
//  - Decode (op / A / B / dst):
//      addu f21: 0001 / rs / rt / rd
//      subu f23: 0010 / rs / rt / rd
//      jr f08: 0101 / rs / - / 0, out_jr=1
//      ori 0D: 0100 / rs / zext(imm) / rt
//      lui 0F: 0011 / - / imm in B[15:0] / rt
//      lw 23: 0001 / rs / sext(imm) / rt, load
//      sw 2B: 0001 / rs / sext(imm) / 0, store
//      beq 04: 0010 / rs / rt / 0, branch
//      jal 03: 1001 / - / in_pc / 31
//  - Unused operands are driven 0.
//  - Load-use: out_valid & out_is_load & out_dst!=0 & out_dst matches a used source -> stall 1 cycle.
//    in_ready=0, ID/EX loads a bubble (out_valid=0, op 0000, dst 0).
//  - Register 0 never creates a hazard or forward.
//  - flush has highest priority: in_ready=1, the instruction is discarded and a bubble is loaded. No illegal pulse.
//  - Unknown opcode/funct: bubble, in_ready=1, illegal=1 for one cycle.
//  - in_valid=0: bubble. Reset mid-stall clears everything next cycle.
// CONFIGURATION
//  ALU_FWD_EN defined:
//    - Source operands mux rf_rdata -> wb_result (if wb match) -> mem_result (if mem match). EX/MEM wins over MEM/WB.
//    - An EX-stage ALU producer is forwarded next cycle via mem_*, so it needs no stall. Only load-use stalls.
//  ALU_FWD_EN undefined:
//    - mem_result/wb_result are ignored.
//    - Stall while a used source equals (out_valid & out_dst) or (mem_valid & mem_dst).
//    - WB is covered by the write-first regfile.
// STRUCTURE
//  - alu_pkg: alu_op_t enum (NOP=0000, ADDU=0001, SUBU=0010, LUI=0011, OR=0100, PASSA=0101, JAL=1001).
//  - alu_pkg also holds opcode/funct localparams and a decoded-control struct.
//  - Sub-module alu_ctrl_decode (combinational): instr -> control struct + uses_rs/uses_rt/illegal.
//    Hazard, forwarding and the ID/EX register live here.
// TESTING
//  - addu $3,$1,$2 with rf 5/7, no hazards -> next cycle out_op=0001, A=5, B=7, dst=3, out_valid=1.
//  - lw $4,8($1) then addu $5,$4,$2:
//      in_ready=0 for 1 cycle, bubble (out_valid=0, op 0000), then addu issued.
//  - ALU_FWD_EN: ori $6,$0,0x1234 then subu $7,$6,$6 ->
//      A=B=0x00001234 via mem_result, no stall.
//    Without the macro: 2 stall cycles.
//  - jal at pc 0x00400010 -> op=1001, B=0x00400010, dst=31. lui $8,0xABCD -> op=0011, B[15:0]=0xABCD.
//  - flush with valid addu, or opcode 0x3F -> bubble issued.
//      Opcode 0x3F pulses illegal once; the flush case does not. in_ready=1 in both.
//  - Assert rst mid-stall -> all outputs 0 immediately (async), in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ID->EX issue stage: ALU op codes, MIPS opcode/funct values,
// the decoded-control record and the register-match helper used for hazards and forwarding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'b0000,
    ALU_ADDU  = 4'b0001,
    ALU_SUBU  = 4'b0010,
    ALU_LUI   = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_PASSA = 4'b0101,
    ALU_JAL   = 4'b1001
  } alu_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  typedef enum logic [2:0] {B_ZERO, B_RT, B_ZIMM, B_SIMM, B_PC} b_sel_t;
  typedef enum logic [1:0] {D_NONE, D_RD, D_RT, D_RA} d_sel_t;

  typedef struct packed {
    alu_op_t op;
    logic    a_rs;
    b_sel_t  b_sel;
    d_sel_t  d_sel;
    logic    is_load;
    logic    is_store;
    logic    jr;
    logic    branch;
  } ctrl_t;

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic src_hit(input logic vld, input logic [4:0] dst, input logic [4:0] idx);
    return vld && (idx != 5'd0) && (dst == idx);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decoder: opcode/funct -> control record, source-usage flags and illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rs,
  output logic       o_uses_rt,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_RTYPE: begin
        case (i_funct)
          FN_ADDU, FN_SUBU: begin
            o_ctrl.op    = (i_funct == FN_ADDU) ? ALU_ADDU : ALU_SUBU;
            o_ctrl.a_rs  = 1'b1;
            o_ctrl.b_sel = B_RT;
            o_ctrl.d_sel = D_RD;
            o_uses_rs    = 1'b1;
            o_uses_rt    = 1'b1;
          end
          FN_JR: begin
            o_ctrl.op   = ALU_PASSA;
            o_ctrl.a_rs = 1'b1;
            o_ctrl.jr   = 1'b1;
            o_uses_rs   = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_ORI: begin
        o_ctrl.op    = ALU_OR;
        o_ctrl.a_rs  = 1'b1;
        o_ctrl.b_sel = B_ZIMM;
        o_ctrl.d_sel = D_RT;
        o_uses_rs    = 1'b1;
      end
      OPC_LUI: begin
        o_ctrl.op    = ALU_LUI;
        o_ctrl.b_sel = B_ZIMM;
        o_ctrl.d_sel = D_RT;
      end
      OPC_LW: begin
        o_ctrl.op      = ALU_ADDU;
        o_ctrl.a_rs    = 1'b1;
        o_ctrl.b_sel   = B_SIMM;
        o_ctrl.d_sel   = D_RT;
        o_ctrl.is_load = 1'b1;
        o_uses_rs      = 1'b1;
      end
      OPC_SW: begin
        // rt is the store data, so it is a source even though B carries the offset
        o_ctrl.op       = ALU_ADDU;
        o_ctrl.a_rs     = 1'b1;
        o_ctrl.b_sel    = B_SIMM;
        o_ctrl.is_store = 1'b1;
        o_uses_rs       = 1'b1;
        o_uses_rt       = 1'b1;
      end
      OPC_BEQ: begin
        o_ctrl.op     = ALU_SUBU;
        o_ctrl.a_rs   = 1'b1;
        o_ctrl.b_sel  = B_RT;
        o_ctrl.branch = 1'b1;
        o_uses_rs     = 1'b1;
        o_uses_rt     = 1'b1;
      end
      OPC_JAL: begin
        o_ctrl.op    = ALU_JAL;
        o_ctrl.b_sel = B_PC;
        o_ctrl.d_sel = D_RA;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, regfile read, hazard stall and ID/EX register, one-cycle latency.
// ALU_FWD_EN: forward from EX/MEM and MEM/WB and stall only on load-use; otherwise stall on any in-flight producer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               mem_valid,
  input  logic [RADDR_W-1:0] mem_dst,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_dst,
  input  logic [XLEN-1:0]    wb_result,
  output logic               out_valid,
  output logic [3:0]         out_op,
  output logic [XLEN-1:0]    out_a,
  output logic [XLEN-1:0]    out_b,
  output logic [RADDR_W-1:0] out_dst,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic [XLEN-1:0]    out_sdata,
  output logic               out_jr,
  output logic               out_branch,
  output logic               illegal
);

  logic [4:0]         w_rs, w_rt, w_rd;
  logic [XLEN-1:0]    w_zimm, w_simm, w_src1, w_src2;
  ctrl_t              w_ctrl;
  logic               w_uses_rs, w_uses_rt, w_illegal;
  logic               w_haz_rs, w_haz_rt, w_stall, w_issue;

  logic               r_valid, r_is_load, r_is_store, r_jr, r_branch, r_illegal;
  alu_op_t            r_op;
  logic [XLEN-1:0]    r_a, r_b, r_sdata;
  logic [RADDR_W-1:0] r_dst;

  alu_op_t            w_n_op;
  logic [XLEN-1:0]    w_n_a, w_n_b, w_n_sdata;
  logic [RADDR_W-1:0] w_n_dst;

  assign w_rs   = in_instr[25:21];
  assign w_rt   = in_instr[20:16];
  assign w_rd   = in_instr[15:11];
  assign w_zimm = {{(XLEN-16){1'b0}}, in_instr[15:0]};
  assign w_simm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;

  alu_ctrl_decode u_decode (
    .i_opcode  (in_instr[31:26]),
    .i_funct   (in_instr[5:0]),
    .o_ctrl    (w_ctrl),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt),
    .o_illegal (w_illegal)
  );

`ifdef ALU_FWD_EN
  // EX/MEM is younger than MEM/WB, so it takes priority
  assign w_src1   = src_hit(mem_valid, mem_dst, w_rs) ? mem_result :
                    src_hit(wb_valid, wb_dst, w_rs)   ? wb_result  : rf_rdata1;
  assign w_src2   = src_hit(mem_valid, mem_dst, w_rt) ? mem_result :
                    src_hit(wb_valid, wb_dst, w_rt)   ? wb_result  : rf_rdata2;
  assign w_haz_rs = src_hit(r_valid & r_is_load, r_dst, w_rs);
  assign w_haz_rt = src_hit(r_valid & r_is_load, r_dst, w_rt);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{mem_result, wb_valid, wb_dst, wb_result};
  assign w_src1   = rf_rdata1;
  assign w_src2   = rf_rdata2;
  // MEM/WB needs no stall: the write-first regfile already returns its value
  assign w_haz_rs = src_hit(r_valid, r_dst, w_rs) | src_hit(mem_valid, mem_dst, w_rs);
  assign w_haz_rt = src_hit(r_valid, r_dst, w_rt) | src_hit(mem_valid, mem_dst, w_rt);
`endif

  assign w_stall  = in_valid & ~flush & ((w_uses_rs & w_haz_rs) | (w_uses_rt & w_haz_rt));
  assign in_ready = ~w_stall;
  assign w_issue  = in_valid & ~flush & ~w_illegal & ~w_stall;

  always_comb begin
    w_n_op    = ALU_NOP;
    w_n_a     = '0;
    w_n_b     = '0;
    w_n_dst   = '0;
    w_n_sdata = '0;
    if (w_issue) begin
      w_n_op = w_ctrl.op;
      w_n_a  = w_ctrl.a_rs ? w_src1 : '0;
      case (w_ctrl.b_sel)
        B_RT:    w_n_b = w_src2;
        B_ZIMM:  w_n_b = w_zimm;
        B_SIMM:  w_n_b = w_simm;
        B_PC:    w_n_b = in_pc;
        default: w_n_b = '0;
      endcase
      case (w_ctrl.d_sel)
        D_RD:    w_n_dst = w_rd;
        D_RT:    w_n_dst = w_rt;
        D_RA:    w_n_dst = 5'd31;
        default: w_n_dst = '0;
      endcase
      w_n_sdata = w_ctrl.is_store ? w_src2 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_op       <= ALU_NOP;
      r_a        <= '0;
      r_b        <= '0;
      r_dst      <= '0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_sdata    <= '0;
      r_jr       <= 1'b0;
      r_branch   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_valid    <= w_issue;
      r_op       <= w_n_op;
      r_a        <= w_n_a;
      r_b        <= w_n_b;
      r_dst      <= w_n_dst;
      r_is_load  <= w_issue & w_ctrl.is_load;
      r_is_store <= w_issue & w_ctrl.is_store;
      r_sdata    <= w_n_sdata;
      r_jr       <= w_issue & w_ctrl.jr;
      r_branch   <= w_issue & w_ctrl.branch;
      r_illegal  <= in_valid & ~flush & w_illegal;
    end
  end

  assign out_valid    = r_valid;
  assign out_op       = r_op;
  assign out_a        = r_a;
  assign out_b        = r_b;
  assign out_dst      = r_dst;
  assign out_is_load  = r_is_load;
  assign out_is_store = r_is_store;
  assign out_sdata    = r_sdata;
  assign out_jr       = r_jr;
  assign out_branch   = r_branch;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode table, hand-written hazard/reset sequences, then random
// traffic against an instruction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        mem_valid, wb_valid;
  logic [4:0]  mem_dst, wb_dst;
  logic [31:0] mem_result, wb_result;
  logic        out_valid, out_is_load, out_is_store, out_jr, out_branch, illegal;
  logic [3:0]  out_op;
  logic [31:0] out_a, out_b, out_sdata;
  logic [4:0]  out_dst;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .mem_valid(mem_valid), .mem_dst(mem_dst),
    .mem_result(mem_result), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_result(wb_result),
    .out_valid(out_valid), .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_dst(out_dst),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_sdata(out_sdata),
    .out_jr(out_jr), .out_branch(out_branch), .illegal(illegal)
  );

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic        Y = 1'b1;
  localparam logic        N = 1'b0;
  localparam logic [31:0] Z = 32'd0;

  typedef logic [110:0] obs_t;
  typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_BAD} kind_t;
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        fl;
    obs_t        exp;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t tab [14];

  logic        m_pv, m_pl, n_pv, n_pl, e_ready, hold;
  logic [4:0]  m_pd, n_pd;
  obs_t        e_obs;

  function automatic obs_t mk(input logic v, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] d, input logic ld,
                              input logic st, input logic [31:0] sd, input logic jr,
                              input logic br, input logic ill);
    return {v, op, a, b, d, ld, st, sd, jr, br, ill};
  endfunction

  function automatic obs_t act_obs();
    return mk(out_valid, out_op, out_a, out_b, out_dst, out_is_load, out_is_store,
              out_sdata, out_jr, out_branch, illegal);
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2, input logic fl,
                               input obs_t e);
    vec_t v;
    v.name = nm; v.instr = ins; v.pc = pc; v.r1 = r1; v.r2 = r2; v.fl = fl; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21) return K_ADDU;
        if (ins[5:0] == 6'h23) return K_SUBU;
        if (ins[5:0] == 6'h08) return K_JR;
        return K_BAD;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h03: return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] r, input logic [31:0] rfv);
    if (FWD && r != 5'd0 && mem_valid && mem_dst == r) return mem_result;
    if (FWD && r != 5'd0 && wb_valid && wb_dst == r) return wb_result;
    return rfv;
  endfunction

  function automatic logic busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_pv && m_pd == r && (m_pl || !FWD)) return 1'b1;
    return !FWD && mem_valid && mem_dst == r;
  endfunction

  task automatic model_eval();
    kind_t       k;
    logic [4:0]  rs, rt, rd;
    logic [31:0] va, vb, se, ze;
    logic        urs, urt, stall, issue;
    k  = classify(in_instr);
    rs = in_instr[25:21]; rt = in_instr[20:16]; rd = in_instr[15:11];
    ze = {16'h0000, in_instr[15:0]};
    se = {{16{in_instr[15]}}, in_instr[15:0]};
    urs = k inside {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ};
    urt = k inside {K_ADDU, K_SUBU, K_SW, K_BEQ};
    stall = in_valid && !flush && ((urs && busy(rs)) || (urt && busy(rt)));
    issue = in_valid && !flush && k != K_BAD && !stall;
    va = opval(rs, rf_rdata1);
    vb = opval(rt, rf_rdata2);
    e_ready = !stall;
    e_obs = '0; n_pv = issue; n_pl = issue && k == K_LW; n_pd = 5'd0;
    if (issue) begin
      case (k)
        K_ADDU: begin e_obs = mk(Y, 4'd1, va, vb, rd, N, N, Z, N, N, N); n_pd = rd; end
        K_SUBU: begin e_obs = mk(Y, 4'd2, va, vb, rd, N, N, Z, N, N, N); n_pd = rd; end
        K_JR:   e_obs = mk(Y, 4'd5, va, Z, 5'd0, N, N, Z, Y, N, N);
        K_ORI:  begin e_obs = mk(Y, 4'd4, va, ze, rt, N, N, Z, N, N, N); n_pd = rt; end
        K_LUI:  begin e_obs = mk(Y, 4'd3, Z, ze, rt, N, N, Z, N, N, N); n_pd = rt; end
        K_LW:   begin e_obs = mk(Y, 4'd1, va, se, rt, Y, N, Z, N, N, N); n_pd = rt; end
        K_SW:   e_obs = mk(Y, 4'd1, va, se, 5'd0, N, Y, vb, N, N, N);
        K_BEQ:  e_obs = mk(Y, 4'd2, va, vb, 5'd0, N, N, Z, N, Y, N);
        K_JAL:  begin e_obs = mk(Y, 4'd9, Z, in_pc, 5'd31, N, N, Z, N, N, N); n_pd = 5'd31; end
        default: e_obs = '0;
      endcase
    end else if (in_valid && !flush && k == K_BAD) begin
      e_obs = mk(N, 4'd0, Z, Z, 5'd0, N, N, Z, N, N, Y);
    end
  endtask

  function automatic logic [31:0] rfv(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : 32'hC0DE_0000 + 32'(r) * 32'h111;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  a, b, d;
    logic [15:0] im;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return rtype(a, b, d, 6'h21);
      1: return rtype(a, b, d, 6'h23);
      2: return rtype(a, 5'd0, 5'd0, 6'h08);
      3: return itype(6'h0D, a, b, im);
      4: return itype(6'h0F, 5'd0, b, im);
      5: return itype(6'h23, a, b, im);
      6: return itype(6'h2B, a, b, im);
      7: return itype(6'h04, a, b, im);
      8: return {6'h03, 26'($urandom)};
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : rtype(a, b, d, 6'h20);
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
    mem_dst = 5'd0; wb_dst = 5'd0; mem_result = Z; wb_result = Z;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_instr = ins; in_pc = 32'h0040_0000; rf_rdata1 = r1; rf_rdata2 = r2; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    in_instr = Z; in_pc = Z; rf_rdata1 = Z; rf_rdata2 = Z;

    tab[0]  = mkv("addu", rtype(5'd1, 5'd2, 5'd3, 6'h21), Z, 32'd5, 32'd7, N,
                  mk(Y, 4'd1, 32'd5, 32'd7, 5'd3, N, N, Z, N, N, N));
    tab[1]  = mkv("subu", rtype(5'd4, 5'd5, 5'd9, 6'h23), Z, 32'd100, 32'd30, N,
                  mk(Y, 4'd2, 32'd100, 32'd30, 5'd9, N, N, Z, N, N, N));
    tab[2]  = mkv("jr", rtype(5'd31, 5'd0, 5'd0, 6'h08), Z, 32'h0040_0100, 32'h55, N,
                  mk(Y, 4'd5, 32'h0040_0100, Z, 5'd0, N, N, Z, Y, N, N));
    tab[3]  = mkv("ori_r0", itype(6'h0D, 5'd0, 5'd6, 16'h1234), Z, Z, 32'h99, N,
                  mk(Y, 4'd4, Z, 32'h1234, 5'd6, N, N, Z, N, N, N));
    tab[4]  = mkv("ori_zext", itype(6'h0D, 5'd1, 5'd6, 16'h8001), Z, 32'hF0F0_F0F0, 32'h99, N,
                  mk(Y, 4'd4, 32'hF0F0_F0F0, 32'h0000_8001, 5'd6, N, N, Z, N, N, N));
    tab[5]  = mkv("lui", itype(6'h0F, 5'd0, 5'd8, 16'hABCD), Z, 32'h77, 32'h88, N,
                  mk(Y, 4'd3, Z, 32'h0000_ABCD, 5'd8, N, N, Z, N, N, N));
    tab[6]  = mkv("lw", itype(6'h23, 5'd1, 5'd4, 16'h0008), Z, 32'h100, 32'h99, N,
                  mk(Y, 4'd1, 32'h100, 32'd8, 5'd4, Y, N, Z, N, N, N));
    tab[7]  = mkv("lw_neg", itype(6'h23, 5'd1, 5'd4, 16'hFFFC), Z, 32'h100, 32'h99, N,
                  mk(Y, 4'd1, 32'h100, 32'hFFFF_FFFC, 5'd4, Y, N, Z, N, N, N));
    tab[8]  = mkv("sw", itype(6'h2B, 5'd1, 5'd2, 16'h000C), Z, 32'h200, 32'hDEAD, N,
                  mk(Y, 4'd1, 32'h200, 32'd12, 5'd0, N, Y, 32'hDEAD, N, N, N));
    tab[9]  = mkv("beq", itype(6'h04, 5'd1, 5'd2, 16'h0010), Z, 32'd3, 32'd3, N,
                  mk(Y, 4'd2, 32'd3, 32'd3, 5'd0, N, N, Z, N, Y, N));
    tab[10] = mkv("jal", {6'h03, 26'h010_0004}, 32'h0040_0010, 32'h11, 32'h22, N,
                  mk(Y, 4'd9, Z, 32'h0040_0010, 5'd31, N, N, Z, N, N, N));
    tab[11] = mkv("bad_op", {6'h3F, 26'h000_0000}, Z, 32'h11, 32'h22, N,
                  mk(N, 4'd0, Z, Z, 5'd0, N, N, Z, N, N, Y));
    tab[12] = mkv("flush", rtype(5'd1, 5'd2, 5'd3, 6'h21), Z, 32'd5, 32'd7, Y, '0);
    tab[13] = mkv("bad_fn", rtype(5'd1, 5'd2, 5'd3, 6'h20), Z, 32'd5, 32'd7, N,
                  mk(N, 4'd0, Z, Z, 5'd0, N, N, Z, N, N, Y));

    @(posedge clk); @(posedge clk); #1;
    chk("reset_outs", act_obs(), '0);
    chk1("reset_ready", in_ready, 1'b1);
    rst = 1'b0;

    // decode table: each vector is followed by a bubble so vectors stay independent
    for (int i = 0; i < 14; i++) begin
      in_instr = tab[i].instr; in_pc = tab[i].pc;
      rf_rdata1 = tab[i].r1; rf_rdata2 = tab[i].r2;
      flush = tab[i].fl; in_valid = 1'b1;
      #1 chk1({tab[i].name, "_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      chk(tab[i].name, act_obs(), tab[i].exp);
      in_valid = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      chk({tab[i].name, "_after"}, act_obs(), '0);
    end

    // load-use: one stall cycle with a bubble, then the consumer issues
    present(itype(6'h23, 5'd1, 5'd4, 16'h0008), 32'h100, Z);
    @(posedge clk); #1;
    chk("lu_lw", act_obs(), mk(Y, 4'd1, 32'h100, 32'd8, 5'd4, Y, N, Z, N, N, N));
    present(rtype(5'd4, 5'd2, 5'd5, 6'h21), 32'h1111, 32'h2222);
    #1 chk1("lu_stall", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("lu_bubble", act_obs(), '0);
    chk1("lu_release", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("lu_addu", act_obs(), mk(Y, 4'd1, 32'h1111, 32'h2222, 5'd5, N, N, Z, N, N, N));

    // a load to $0 never stalls its consumer
    present(itype(6'h23, 5'd1, 5'd0, 16'h0004), 32'h100, Z);
    @(posedge clk); #1;
    present(rtype(5'd0, 5'd2, 5'd5, 6'h21), Z, 32'h2222);
    #1 chk1("r0_no_stall", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("r0_addu", act_obs(), mk(Y, 4'd1, Z, 32'h2222, 5'd5, N, N, Z, N, N, N));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ALU producer followed by a dependent subu
    present(itype(6'h0D, 5'd0, 5'd6, 16'h1234), Z, Z);
    @(posedge clk); #1;
    present(rtype(5'd6, 5'd6, 5'd7, 6'h23), Z, Z);
`ifdef ALU_FWD_EN
    mem_valid = 1'b1; mem_dst = 5'd6; mem_result = 32'h1234;
    #1 chk1("fwd_no_stall", in_ready, 1'b1);
`else
    #1 chk1("nofwd_stall1", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("nofwd_bubble1", act_obs(), '0);
    mem_valid = 1'b1; mem_dst = 5'd6; mem_result = 32'h1234;
    #1 chk1("nofwd_stall2", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("nofwd_bubble2", act_obs(), '0);
    mem_valid = 1'b0; wb_valid = 1'b1; wb_dst = 5'd6; wb_result = 32'h1234;
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h1234;
    #1 chk1("nofwd_release", in_ready, 1'b1);
`endif
    @(posedge clk); #1;
    chk("dep_subu", act_obs(), mk(Y, 4'd2, 32'h1234, 32'h1234, 5'd7, N, N, Z, N, N, N));
    idle_inputs();
    @(posedge clk); #1;

    // asynchronous reset in the middle of a load-use stall
    present(itype(6'h23, 5'd1, 5'd4, 16'h0008), 32'h100, Z);
    @(posedge clk); #1;
    present(rtype(5'd2, 5'd4, 5'd5, 6'h21), 32'h3333, 32'h4444);
    #1 chk1("rst_pre_stall", in_ready, 1'b0);
    #1 rst = 1'b1;
    #1 chk("rst_async", act_obs(), '0);
    rst = 1'b0;
    #1 chk1("rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("rst_addu", act_obs(), mk(Y, 4'd1, 32'h3333, 32'h4444, 5'd5, N, N, Z, N, N, N));
    idle_inputs();
    @(posedge clk); #1;

    // random traffic against the reference model
    m_pv = 1'b0; m_pl = 1'b0; m_pd = 5'd0; hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold) begin
        in_instr = rnd_instr();
        in_pc = $urandom & 32'hFFFF_FFFC;
        in_valid = ($urandom_range(0, 9) != 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      mem_valid = 1'($urandom_range(0, 1)); mem_dst = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_valid = 1'($urandom_range(0, 1)); wb_dst = 5'($urandom_range(0, 7)); wb_result = $urandom;
      rf_rdata1 = rfv(in_instr[25:21]);
      rf_rdata2 = rfv(in_instr[20:16]);
      #1;
      model_eval();
      chk1("rnd_ready", in_ready, e_ready);
      @(posedge clk); #1;
      chk("rnd_out", act_obs(), e_obs);
      m_pv = n_pv; m_pl = n_pl; m_pd = n_pd;
      hold = in_valid && !flush && !e_ready;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
